uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode), validates the opcode, then registers the ALU result and launches a single transmit.
- Aborts a partial frame on an inter-byte timeout measured in baud ticks.
- Flags bytes that arrive while busy.

Parameters:
- NB_DATA, 8, width of operands, UART data and result.
- NB_OP, 6, width of ALU opcode field.
- NB_TIMEOUT, 16, width of the timeout counter.
- TIMEOUT_TICKS, 2560, number of i_s_tick pulses allowed between bytes of one frame (16 frames at 16x oversampling).
- ERR_CODE, 8'hFF, byte transmitted in place of a result on an invalid opcode.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_s_tick  in  1  baud oversampling tick from baudrate_generator, one i_clock wide.
- i_rx_done_tick  in  1  one-cycle pulse from rx_uart; i_rx_data is valid in the same cycle.
- i_rx_data  in  NB_DATA  received byte.
- i_tx_done_tick  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- i_alu_result  in  NB_DATA  combinational ALU output.
- o_data_a  out  NB_DATA  registered operand A to the ALU.
- o_data_b  out  NB_DATA  registered operand B to the ALU.
- o_op  out  NB_OP  registered opcode to the ALU.
- o_tx_start  out  1  one-cycle transmit request.
- o_tx_data  out  NB_DATA  byte to transmit; held stable from o_tx_start until i_tx_done_tick.
- o_busy  out  1  high in S_EXEC, S_TX_START and S_TX_WAIT.
- o_error  out  1  one-cycle pulse on an invalid opcode.
- o_timeout  out  1  one-cycle pulse on frame abort.
- o_overrun  out  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (i_reset=0, asynchronous): state S_WAIT_A; all data outputs 0; all pulse outputs 0; o_busy 0; timeout counter 0.
- States: S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_TX_START, S_TX_WAIT.
- S_WAIT_A:
  - On i_rx_done_tick, load o_data_a and go to S_WAIT_B.
  - No timeout counting in this state.
- S_WAIT_B:
  - On i_rx_done_tick, load o_data_b and go to S_WAIT_OP.
- S_WAIT_OP:
  - On i_rx_done_tick, load o_op <= i_rx_data[NB_OP-1:0] and go to S_EXEC.
  - Opcode valid set: 6'h20 ADD, 6'h22 SUB, 6'h24 AND, 6'h25 OR, 6'h26 XOR, 6'h27 NOR, 6'h03 SRA, 6'h02 SRL.
  - The opcode is valid only if i_rx_data[NB_DATA-1:NB_OP]==0 and the low bits are in the valid set; the valid flag is registered alongside o_op.
- Timeout (S_WAIT_B and S_WAIT_OP only):
  - Counter clears on entry to either state and on every i_rx_done_tick; it increments on i_s_tick.
  - When an i_s_tick would make the count equal TIMEOUT_TICKS: pulse o_timeout, go to S_WAIT_A. o_data_a, o_data_b and o_op keep their old values.
  - If i_rx_done_tick and the terminal tick occur in the same cycle, the byte wins: it is accepted and there is no timeout.
- S_EXEC (exactly 1 cycle):
  - Valid opcode: o_tx_data <= i_alu_result.
  - Invalid opcode: o_tx_data <= ERR_CODE and o_error pulses in this cycle.
  - Next state S_TX_START.
- S_TX_START (1 cycle):
  - o_tx_start=1, then go to S_TX_WAIT.
  - Latency: last rx_done at cycle n, EXEC at n+1, o_tx_start at n+2.
- S_TX_WAIT:
  - On i_tx_done_tick, go to S_WAIT_A; o_tx_data holds its value.
  - i_tx_done_tick in any other state is ignored.
- Overrun:
  - i_rx_done_tick in S_EXEC, S_TX_START or S_TX_WAIT drops the byte and pulses o_overrun the next cycle.
  - Registers and state are unchanged.
- Reset mid-operation: immediate return to reset values, including o_tx_start deasserted.

Test Plan:
- Bytes 8'h05, 8'h03, 8'h20 with ALU model -> o_tx_start one cycle, 2 clocks after the third rx_done; o_tx_data=8'h08; after tx_done, state S_WAIT_A with o_busy=0.
- Bytes 8'h03, 8'h05, 8'h22 -> o_tx_data=8'hFE; o_error=0.
- Invalid opcode 8'h11, then separately 8'hE0 -> o_error pulse, o_tx_data=8'hFF, one transmit each.
- Byte A then no traffic for 2560 s_ticks -> o_timeout pulse on tick 2560, no o_tx_start. A following full frame 8'h0F, 8'hF0, 8'h25 -> o_tx_data=8'hFF with o_error=0.
- Extra rx_done during S_TX_WAIT -> o_overrun pulse; next frame decodes correctly. Separately, a byte coincident with the terminal timeout tick is accepted.
- i_reset asserted low during S_TX_WAIT -> all outputs 0 asynchronously; a full frame after release completes normally.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between the UART pair and the ALU: gathers operand A, operand B
// and an opcode, then sends back either the registered ALU result or an error byte.
module uart_alu_ctrl #(
    parameter int                 NB_DATA       = 8,
    parameter int                 NB_OP         = 6,
    parameter int                 NB_TIMEOUT    = 16,
    parameter int                 TIMEOUT_TICKS = 2560,
    parameter logic [NB_DATA-1:0] ERR_CODE      = 8'hFF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_error,
    output logic               o_timeout,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_TX_START,
        S_TX_WAIT
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] TERMINAL_CNT = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

    state_t                state;
    state_t                state_next;
    logic [NB_TIMEOUT-1:0] tick_cnt;
    logic                  op_valid;
    logic                  in_frame;
    logic                  terminal;

    // Upper byte bits must be clear; the low bits must name a supported ALU operation.
    function automatic logic is_valid_op(input logic [NB_DATA-1:0] b);
        logic [NB_OP-1:0] code;
        logic             hit;
        code = b[NB_OP-1:0];
        case (code)
            NB_OP'('h20), NB_OP'('h22), NB_OP'('h24), NB_OP'('h25),
            NB_OP'('h26), NB_OP'('h27), NB_OP'('h03), NB_OP'('h02): hit = 1'b1;
            default:                                                  hit = 1'b0;
        endcase
        return hit && (b[NB_DATA-1:NB_OP] == '0);
    endfunction

    assign in_frame = (state == S_WAIT_B) || (state == S_WAIT_OP);
    // A byte arriving on the terminal tick takes priority over the abort.
    assign terminal = in_frame && i_s_tick && !i_rx_done_tick && (tick_cnt == TERMINAL_CNT);

    assign o_busy     = (state == S_EXEC) || (state == S_TX_START) || (state == S_TX_WAIT);
    assign o_tx_start = (state == S_TX_START);
    assign o_error    = (state == S_EXEC) && !op_valid;
    assign o_timeout  = terminal;

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_WAIT_A:   if (i_rx_done_tick) state_next = S_WAIT_B;
            S_WAIT_B: begin
                if (i_rx_done_tick)  state_next = S_WAIT_OP;
                else if (terminal)   state_next = S_WAIT_A;
            end
            S_WAIT_OP: begin
                if (i_rx_done_tick)  state_next = S_EXEC;
                else if (terminal)   state_next = S_WAIT_A;
            end
            S_EXEC:     state_next = S_TX_START;
            S_TX_START: state_next = S_TX_WAIT;
            S_TX_WAIT:  if (i_tx_done_tick) state_next = S_WAIT_A;
            default:    state_next = S_WAIT_A;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_WAIT_A;
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_op      <= '0;
            op_valid  <= 1'b0;
            o_tx_data <= '0;
            tick_cnt  <= '0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_next;
            o_overrun <= i_rx_done_tick && o_busy;

            if (i_rx_done_tick) begin
                case (state)
                    S_WAIT_A:  o_data_a <= i_rx_data;
                    S_WAIT_B:  o_data_b <= i_rx_data;
                    S_WAIT_OP: begin
                        o_op     <= i_rx_data[NB_OP-1:0];
                        op_valid <= is_valid_op(i_rx_data);
                    end
                    default: ;
                endcase
            end

            if (state == S_EXEC)
                o_tx_data <= op_valid ? i_alu_result : ERR_CODE;

            // Counter idles at zero outside a frame, so entry to S_WAIT_B starts from zero.
            if (!in_frame || i_rx_done_tick || terminal)
                tick_cnt <= '0;
            else if (i_s_tick)
                tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: a table of full frames plus hand-written
// timeout, overrun and mid-transmit reset sequences.
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_tick;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       error;
    logic       timeout;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_alu_ctrl dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_s_tick       (s_tick),
        .i_rx_done_tick (rx_done),
        .i_rx_data      (rx_data),
        .i_tx_done_tick (tx_done),
        .i_alu_result   (alu_result),
        .o_data_a       (data_a),
        .o_data_b       (data_b),
        .o_op           (op),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .o_busy         (busy),
        .o_error        (error),
        .o_timeout      (timeout),
        .o_overrun      (overrun)
    );

    // Behavioural stand-in for the external combinational ALU.
    always_comb begin
        alu_result = 8'h00;
        case (op)
            6'h20: alu_result = data_a + data_b;
            6'h22: alu_result = data_a - data_b;
            6'h24: alu_result = data_a & data_b;
            6'h25: alu_result = data_a | data_b;
            6'h26: alu_result = data_a ^ data_b;
            6'h27: alu_result = ~(data_a | data_b);
            6'h03: alu_result = 8'($signed(data_a) >>> data_b);
            6'h02: alu_result = data_a >> data_b;
            default: alu_result = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [7:0] exp_tx;
        logic       exp_err;
    } frame_t;

    frame_t vec [10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = d;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    // Called right after the opcode byte is accepted; walks EXEC, TX_START, TX_WAIT.
    task automatic exec_checks(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                               input logic [7:0] exp_tx, input logic exp_err);
        logic [5:0] exp_op;
        exp_op = opb[5:0];
        @(negedge clk);
        check("exec_busy", busy, 1);
        check("exec_error", error, exp_err);
        check("exec_tx_start", tx_start, 0);
        check("data_a", data_a, a);
        check("data_b", data_b, b);
        check("op", op, exp_op);
        @(negedge clk);
        check("tx_start_pulse", tx_start, 1);
        check("tx_data", tx_data, exp_tx);
        check("start_error", error, 0);
        @(negedge clk);
        check("tx_start_drop", tx_start, 0);
        check("tx_wait_data", tx_data, exp_tx);
        check("tx_wait_busy", busy, 1);
    endtask

    task automatic tx_done_pulse(input logic [7:0] exp_tx);
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_tx_data_held", tx_data, exp_tx);
    endtask

    task automatic run_frame(input frame_t f);
        send_byte(f.a);
        send_byte(f.b);
        send_byte(f.opb);
        exec_checks(f.a, f.b, f.opb, f.exp_tx, f.exp_err);
        tx_done_pulse(f.exp_tx);
    endtask

    initial begin
        logic early_to;
        logic start_seen;

        vec[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};
        vec[1] = '{8'h03, 8'h05, 8'h22, 8'hFE, 1'b0};
        vec[2] = '{8'h0F, 8'hF0, 8'h24, 8'h00, 1'b0};
        vec[3] = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0};
        vec[4] = '{8'h0F, 8'hF0, 8'h26, 8'hFF, 1'b0};
        vec[5] = '{8'h0F, 8'hF0, 8'h27, 8'h00, 1'b0};
        vec[6] = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b0};
        vec[7] = '{8'h80, 8'h02, 8'h02, 8'h20, 1'b0};
        vec[8] = '{8'h05, 8'h03, 8'h11, 8'hFF, 1'b1};
        vec[9] = '{8'h05, 8'h03, 8'hE0, 8'hFF, 1'b1};

        rst_n   = 1'b0;
        s_tick  = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_data_a", data_a, 0);
        check("rst_pulses", {error, timeout, overrun}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_frame(vec[i]);

        // A stray tx_done mid-frame must be ignored.
        send_byte(8'h05);
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        send_byte(8'h03);
        send_byte(8'h20);
        exec_checks(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
        tx_done_pulse(8'h08);

        // Timeout: operand A then 2560 consecutive ticks with no traffic.
        send_byte(8'hAA);
        s_tick     = 1'b1;
        early_to   = 1'b0;
        start_seen = 1'b0;
        for (int i = 1; i <= 2560; i++) begin
            @(negedge clk);
            start_seen |= tx_start;
            if (i < 2560) early_to |= timeout;
            else          check("timeout_pulse", timeout, 1);
            @(posedge clk); #1;
        end
        s_tick = 1'b0;
        @(negedge clk);
        check("timeout_early", early_to, 0);
        check("timeout_no_start", start_seen, 0);
        check("timeout_single", timeout, 0);
        check("timeout_keeps_a", data_a, 8'hAA);
        run_frame('{8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0});

        // Byte coincident with the terminal tick is accepted.
        send_byte(8'h12);
        s_tick = 1'b1;
        repeat (2559) @(posedge clk);
        #1;
        rx_done = 1'b1;
        rx_data = 8'h34;
        @(negedge clk);
        check("coincide_no_timeout", timeout, 0);
        @(posedge clk); #1;
        rx_done = 1'b0;
        s_tick  = 1'b0;
        send_byte(8'h20);
        exec_checks(8'h12, 8'h34, 8'h20, 8'h46, 1'b0);
        tx_done_pulse(8'h46);

        // Overrun: extra byte while waiting for the transmitter.
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        exec_checks(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = 8'h55;
        @(posedge clk); #1;
        rx_done = 1'b0;
        @(negedge clk);
        check("overrun_pulse", overrun, 1);
        check("overrun_tx_data", tx_data, 8'h08);
        check("overrun_busy", busy, 1);
        check("overrun_data_a", data_a, 8'h05);
        @(negedge clk);
        check("overrun_single", overrun, 0);
        tx_done_pulse(8'h08);
        run_frame(vec[1]);

        // Asynchronous reset while waiting for the transmitter.
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_tx_data", tx_data, 0);
        check("async_rst_ops", {data_a, data_b, 2'b00, op}, 0);
        check("async_rst_tx_start", tx_start, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(vec[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit %0d ns", 2_000_000);
        $fatal(1);
    end

endmodule
